// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue in front of a UART transmitter.
// A circular buffer with first-word fall-through presentation. The head byte is
// shown on tx_data/tx_wren and is popped when the transmitter pulses tx_accept.
// Pushes that arrive while the queue is full are dropped, and the sticky
// overflow flag records them. The flush input discards everything queued.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 12
) (
    input  logic                       uart_clock,
    input  logic                       reset,
    input  logic [7:0]                 wr_data,
    input  logic                       wr_en,
    input  logic                       flush,
    output logic                       full,
    output logic                       almost_full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 tx_data,
    output logic                       tx_wren,
    input  logic                       tx_accept
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;

    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;

    // The depth is a power of two, so the pointers wrap from DEPTH-1 to 0 naturally.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return ptr + AW'(1);
    endfunction

    // Status flags come straight from the registered count, so they add no extra lag.
    always_comb begin
        full_s  = (count_r == CW'(DEPTH));
        empty_s = (count_r == CW'(0));
    end

    // Classify this cycle's request. A pop frees a slot, so a push is taken even when the queue is full.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        drop_s = 1'b0;
        if (tx_accept && !empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (wr_en && (!full_s || pop_s)) begin
            push_s = 1'b1;
        end else if (wr_en) begin
            drop_s = 1'b1;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Buffer storage. It has no reset, and a flush cycle writes nothing.
    always_ff @(posedge uart_clock) begin
        if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and the sticky overflow flag. Flush takes priority over push and pop.
    always_ff @(posedge uart_clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= AW'(0);
            rd_ptr_r   <= AW'(0);
            count_r    <= CW'(0);
            overflow_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r   <= AW'(0);
            rd_ptr_r   <= AW'(0);
            count_r    <= CW'(0);
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Drive the outputs. The head byte falls through to the transmitter as soon as it is stored.
    always_comb begin
        full        = full_s;
        empty       = empty_s;
        almost_full = (count_r >= CW'(ALMOST_FULL));
        count       = count_r;
        overflow    = overflow_r;
        tx_wren     = !empty_s;
        tx_data     = mem_r[rd_ptr_r];
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
// The stimulus process drives the inputs. It decides from queue occupancy
// whether each push is accepted, and it pushes accepted bytes into an expected
// queue. A separate monitor runs on the falling edge. It compares the flags
// with the reference queue, and on every accepted pop it compares tx_data with
// the oldest expected byte.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic       uart_clock = 1'b0;
    logic       reset      = 1'b1;
    logic [7:0] wr_data    = 8'h00;
    logic       wr_en      = 1'b0;
    logic       flush      = 1'b0;
    logic       tx_accept  = 1'b0;
    logic       full, almost_full, empty, overflow, tx_wren;
    logic [4:0] count;
    logic [7:0] tx_data;

    // Reference model: bytes expected in the queue, plus the sticky overflow flag.
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;

    // Effect of the inputs driven this cycle, applied after the next rising edge.
    logic       p_push, p_drop, p_flush;
    logic [7:0] p_data;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
        .uart_clock (uart_clock),
        .reset      (reset),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .flush      (flush),
        .full       (full),
        .almost_full(almost_full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .tx_data    (tx_data),
        .tx_wren    (tx_wren),
        .tx_accept  (tx_accept)
    );

    always #5 uart_clock = ~uart_clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs. Call it at posedge+1; it returns at the next posedge+1.
    task automatic cycle(input logic w, input logic [7:0] d, input logic a, input logic f);
        logic pop;
        wr_en     = w;
        wr_data   = d;
        tx_accept = a;
        flush     = f;
        pop       = a && (exp_q.size() > 0);
        p_push    = w && ((exp_q.size() < DEPTH) || pop);
        p_drop    = w && !p_push;
        p_flush   = f;
        p_data    = d;
        @(posedge uart_clock);
        #1;
        if (p_flush) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            if (p_push) exp_q.push_back(p_data);
            if (p_drop) exp_ovf = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Monitor: check the flags against the model, then score any pop the transmitter makes.
    initial begin
        forever begin
            @(negedge uart_clock);
            if (!reset) begin
                chk("count",       32'(count),       32'(exp_q.size()));
                chk("empty",       32'(empty),       32'(exp_q.size() == 0));
                chk("full",        32'(full),        32'(exp_q.size() == DEPTH));
                chk("almost_full", 32'(almost_full), 32'(exp_q.size() >= AF));
                chk("tx_wren",     32'(tx_wren),     32'(exp_q.size() > 0));
                chk("overflow",    32'(overflow),    32'(exp_ovf));
                if (tx_accept && exp_q.size() > 0) begin
                    chk("tx_data", 32'(tx_data), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus: directed cases first, then randomized traffic.
    initial begin
        logic w, a, f;
        // Reset state.
        repeat (3) @(posedge uart_clock);
        #1;
        chk("reset_count",   32'(count),   32'd0);
        chk("reset_empty",   32'(empty),   32'd1);
        chk("reset_tx_wren", 32'(tx_wren), 32'd0);
        reset = 1'b0;

        // A single byte appears one cycle after it is pushed.
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        chk("lat1_data", 32'(tx_data), 32'h41);
        chk("lat1_wren", 32'(tx_wren), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Three bytes are read out in order, and then the queue is empty.
        for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);

        // Overfill: the 17th byte is dropped and overflow is set.
        for (int i = 0; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        chk("ovf_full",  32'(full),     32'd1);
        chk("ovf_flag",  32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ovf_drained_still_sticky", 32'(overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // At full, a push with a pop in the same cycle is accepted, and the new byte comes out last.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("fullpp_count", 32'(count),    32'd16);
        chk("fullpp_ovf",   32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // almost_full is set at 12 bytes, then a flush empties the queue.
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        chk("af_at_12", 32'(almost_full), 32'd1);
        cycle(1'b1, 8'h77, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);

        // "HI" is drained back-to-back by a transmitter that accepts every cycle.
        cycle(1'b1, 8'h48, 1'b0, 1'b0);
        cycle(1'b1, 8'h49, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);

        // A reset in the middle of a transfer takes effect at once and discards the queue.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_count",   32'(count),   32'd0);
        chk("midrst_tx_wren", 32'(tx_wren), 32'd0);
        chk("midrst_empty",   32'(empty),   32'd1);
        exp_q.delete();
        exp_ovf = 1'b0;
        @(posedge uart_clock);
        #1;
        reset = 1'b0;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);

        // Randomized traffic, alternating between phases biased toward filling and toward draining.
        for (int i = 0; i < 1200; i++) begin
            if ((i / 150) % 2 == 0) begin
                w = ($urandom_range(0, 99) < 75);
                a = ($urandom_range(0, 99) < 30);
            end else begin
                w = ($urandom_range(0, 99) < 30);
                a = ($urandom_range(0, 99) < 75);
            end
            f = ($urandom_range(0, 299) == 0);
            cycle(w, 8'($urandom), a, f);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >= 2).
REQ-002 SHALL have parameter ALMOST_FULL, default 12, count threshold for almost_full (1..DEPTH).
REQ-003 SHALL have port: uart_clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: wr_data  input  8  byte to enqueue.
REQ-006 SHALL have port: wr_en  input  1  push request, one byte per cycle high.
REQ-007 SHALL have port: flush  input  1  synchronous discard of all queued bytes.
REQ-008 SHALL have port: full  output  1  count == DEPTH.
REQ-009 SHALL have port: almost_full  output  1  count >= ALMOST_FULL.
REQ-010 SHALL have port: empty  output  1  count == 0.
REQ-011 SHALL have port: count  output  $clog2(DEPTH)+1  bytes currently queued.
REQ-012 SHALL have port: overflow  output  1  sticky, a push was dropped.
REQ-013 SHALL have port: tx_data  output  8  head byte, to transmitter tx_data.
REQ-014 SHALL have port: tx_wren  output  1  head valid, to transmitter tx_wren.
REQ-015 SHALL have port: tx_accept  input  1  one-cycle pulse from transmitter: head byte latched.
REQ-016 SHALL use one clock (uart_clock) and an asynchronous, active-high reset (reset); both fixed.

Function
REQ-017 SHALL store bytes in a DEPTH x 8 circular buffer with write pointer, read pointer and count; pointers wrap from DEPTH-1 to 0.
REQ-018 SHALL drive tx_wren = ~empty and tx_data = buffer[read pointer] combinationally (first-word fall-through); tx_data stable while tx_wren high until pop.
REQ-019 Pop: tx_accept == 1 and ~empty -> read pointer +1, count -1 at that edge.
REQ-020 tx_accept == 1 while empty SHALL be ignored (no pointer/count change, no flag).
REQ-021 Push: wr_en == 1 and (~full or pop same cycle) -> wr_data written at write pointer, write pointer +1, count +1.
REQ-022 wr_en == 1 while full and no pop same cycle SHALL drop the byte, leave state unchanged, set overflow.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and advance both pointers; at count==DEPTH the popped slot is the one written.
REQ-024 A byte pushed into an empty FIFO SHALL appear on tx_data with tx_wren=1 in the following cycle (latency 1).
REQ-025 flush SHALL, at the next edge, zero both pointers and count and clear overflow, overriding any push/pop in that cycle.
REQ-026 full, almost_full, empty SHALL be derived from registered count (no extra lag).
REQ-027 overflow SHALL remain 1 until flush or reset.
REQ-028 Buffer contents SHALL not be reset; only pointers, count, overflow.

Reset
REQ-029 reset high SHALL immediately force: count=0, pointers=0, empty=1, full=0, almost_full=0, overflow=0, tx_wren=0.
REQ-030 reset mid-transfer SHALL discard all queued bytes; post-release, no byte emitted until a new push.

Verification
REQ-031 Reset, push 0x41 -> next cycle tx_wren=1, tx_data=0x41, count=1, empty=0.
REQ-032 Push 0x01..0x03, pulse tx_accept three times (one per pop) -> tx_data 0x01, 0x02, 0x03 in order, then empty=1, tx_wren=0.
REQ-033 Push 17 bytes 0x00..0x10 (DEPTH=16), no pops -> full=1 after 16th, 17th dropped, overflow=1, count=16; drain yields 0x00..0x0F.
REQ-034 At full, wr_en=1 with tx_accept=1 same cycle -> count stays 16, overflow stays 0, new byte read out last.
REQ-035 Push 12 bytes -> almost_full=1 at count 12; flush -> count=0, empty=1, overflow=0 next cycle.
REQ-036 Connected to the uart transmitter at 8N1, push "HI" (0x48,0x49) -> tx line carries both frames back-to-back, FIFO empty afterwards.
